// File: rtl/tlul_host_bridge_pkg.sv
// Constants and helpers for the req/gnt to TL-UL host bridge.
package tlul_host_bridge_pkg;

    localparam logic [15:0] HostAUserDefault = 16'h0000;

    // Non-zero masks whose set bits form one contiguous run.
    function automatic logic mask_legal(logic [3:0] be);
        logic ok;
        unique case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b0110, 4'b1100,
            4'b0111, 4'b1110, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by hosts and devices on tl_xbar_main.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_bridge_if.sv
// Local req/gnt/rvalid memory port; names follow the bridge's point of view.
interface tlul_host_bridge_if;

    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/tlul_host_rsp_buf.sv
// Reorder buffer: slots allocated in issue order, filled by source index, retired in order.
module tlul_host_rsp_buf #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned SourceBase     = 0,
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alloc_i,
    input  logic            alloc_we_i,
    input  logic            alloc_err_i,
    input  logic            fill_i,
    input  logic [7:0]      fill_source_i,
    input  logic [31:0]     fill_data_i,
    input  logic            fill_err_i,
    output logic [PtrW-1:0] issue_ptr_o,
    output logic [CntW-1:0] count_o,
    output logic            rvalid_o,
    output logic [31:0]     rdata_o,
    output logic            err_o,
    output logic            unexp_rsp_o
);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [MaxOutstanding-1:0] slot_valid_q, slot_valid_d;
    logic [MaxOutstanding-1:0] slot_done_q, slot_done_d;
    logic [MaxOutstanding-1:0] slot_we_q, slot_we_d;
    logic [MaxOutstanding-1:0] slot_err_q, slot_err_d;
    logic [31:0]               slot_data_q [MaxOutstanding];
    logic [31:0]               slot_data_d [MaxOutstanding];

    logic [PtrW-1:0] issue_ptr_q, issue_ptr_d;
    logic [PtrW-1:0] retire_ptr_q, retire_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            unexp_q, unexp_d;

    logic [31:0]     fill_idx;
    logic [PtrW-1:0] fill_slot;
    logic            fill_ok;
    logic            retire;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Sources below SourceBase wrap to a huge index and are rejected as out of range.
    assign fill_idx  = 32'(fill_source_i) - SourceBase;
    assign fill_slot = fill_idx[PtrW-1:0];
    assign fill_ok   = fill_i && (fill_idx < MaxOutstanding) &&
                       slot_valid_q[fill_slot] && !slot_done_q[fill_slot];

    // A beat for the oldest slot retires straight away so the response costs one cycle.
    assign retire = slot_valid_q[retire_ptr_q] &&
                    (slot_done_q[retire_ptr_q] || (fill_ok && fill_slot == retire_ptr_q));

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_done_d  = slot_done_q;
        slot_we_d    = slot_we_q;
        slot_err_d   = slot_err_q;
        slot_data_d  = slot_data_q;
        issue_ptr_d  = issue_ptr_q;
        retire_ptr_d = retire_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;
        unexp_d      = unexp_q;

        if (fill_i && !fill_ok) begin
            unexp_d = 1'b1;
        end

        if (fill_ok) begin
            slot_done_d[fill_slot] = 1'b1;
            slot_data_d[fill_slot] = slot_we_q[fill_slot] ? '0 : fill_data_i;
            slot_err_d[fill_slot]  = fill_err_i;
        end

        if (retire) begin
            rsp_valid_d                = 1'b1;
            rsp_data_d                 = slot_data_d[retire_ptr_q];
            rsp_err_d                  = slot_err_d[retire_ptr_q];
            slot_valid_d[retire_ptr_q] = 1'b0;
            slot_done_d[retire_ptr_q]  = 1'b0;
            retire_ptr_d               = ptr_inc(retire_ptr_q);
        end

        // Rejected requests are born done so they still retire in issue order.
        if (alloc_i) begin
            slot_valid_d[issue_ptr_q] = 1'b1;
            slot_we_d[issue_ptr_q]    = alloc_we_i;
            slot_done_d[issue_ptr_q]  = alloc_err_i;
            slot_err_d[issue_ptr_q]   = alloc_err_i;
            slot_data_d[issue_ptr_q]  = '0;
            issue_ptr_d               = ptr_inc(issue_ptr_q);
        end

        if (alloc_i && !retire) begin
            count_d = count_q + CntW'(1);
        end else if (!alloc_i && retire) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            slot_done_q  <= '0;
            slot_we_q    <= '0;
            slot_err_q   <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                slot_data_q[i] <= '0;
            end
            issue_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            unexp_q      <= 1'b0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_done_q  <= slot_done_d;
            slot_we_q    <= slot_we_d;
            slot_err_q   <= slot_err_d;
            for (int i = 0; i < MaxOutstanding; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
            issue_ptr_q  <= issue_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            unexp_q      <= unexp_d;
        end
    end

    assign issue_ptr_o = issue_ptr_q;
    assign count_o     = count_q;
    assign rvalid_o    = rsp_valid_q;
    assign rdata_o     = rsp_data_q;
    assign err_o       = rsp_err_q;
    assign unexp_rsp_o = unexp_q;

endmodule

// File: rtl/tlul_host_bridge.sv
// TL-UL host bridge: local req/gnt port in, TL-UL A/D channels out, responses in issue order.
// Optional request legality checking is enabled by defining TLUL_HOST_ALIGN_CHECK_EN.
module tlul_host_bridge
    import tlul_pkg::*;
    import tlul_host_bridge_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned SourceBase     = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    tlul_host_bridge_if.slave host,
    output tl_h2d_t           tl_o,
    input  tl_d2h_t           tl_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [PtrW-1:0] issue_ptr;
    logic [CntW-1:0] count;
    logic            full;
    logic            space;
    logic            illegal;
    logic            send;
    logic            unexp_rsp;
    logic            unused_sig;

`ifdef TLUL_HOST_ALIGN_CHECK_EN
    assign illegal = (host.addr_i[1:0] != 2'b00) || !mask_legal(host.be_i);
`else
    assign illegal = 1'b0;
`endif

    assign full  = (count == CntW'(MaxOutstanding));
    assign space = rst_ni && !full;
    assign send  = host.req_i && space && !illegal;

    // Illegal requests are granted locally without waiting on the bus.
    assign host.gnt_o = host.req_i && space && (illegal || tl_i.a_ready);

    always_comb begin
        tl_o           = '0;
        tl_o.d_ready   = 1'b1;
        tl_o.a_valid   = send;
        tl_o.a_opcode  = Get;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = 8'(SourceBase + 32'(issue_ptr));
        tl_o.a_address = {host.addr_i[31:2], 2'b00};
        tl_o.a_mask    = 4'hF;
        tl_o.a_user    = HostAUserDefault;
        if (host.we_i) begin
            if (host.be_i == 4'hF) begin
                tl_o.a_opcode = PutFullData;
            end else begin
                tl_o.a_opcode = PutPartialData;
            end
            tl_o.a_mask = host.be_i;
            tl_o.a_data = host.wdata_i;
        end
    end

    tlul_host_rsp_buf #(
        .MaxOutstanding (MaxOutstanding),
        .SourceBase     (SourceBase)
    ) u_rsp_buf (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (host.gnt_o),
        .alloc_we_i    (host.we_i),
        .alloc_err_i   (illegal),
        .fill_i        (tl_i.d_valid),
        .fill_source_i (tl_i.d_source),
        .fill_data_i   (tl_i.d_data),
        .fill_err_i    (tl_i.d_error),
        .issue_ptr_o   (issue_ptr),
        .count_o       (count),
        .rvalid_o      (host.rvalid_o),
        .rdata_o       (host.rdata_o),
        .err_o         (host.err_o),
        .unexp_rsp_o   (unexp_rsp)
    );

    // D-channel sideband and the byte offset carry nothing the bridge needs.
    assign unused_sig = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                          tl_i.d_user, host.addr_i[1:0], unexp_rsp};

endmodule
